// File: rtl/score_pkg.sv
// Shared types and default parameters for the score-counter input front end.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_RELEASE
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/key_conditioner.sv
// Synchronizes one raw key, debounces it, and flags the cycle after the
// debounced level rises.
module key_conditioner
  import score_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_bit;

  assign sync_bit = sync[SYNC_STAGES-1];

  // Synchronizer chain: bit 0 samples the raw key.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], key};
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_bit == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_bit;
        rise  <= sync_bit;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_input_ctrl.sv
// Turns debounced up/down key presses into single-cycle increment requests for
// the digit chain, with optional saturation and sticky wrap flags.
module score_input_ctrl
  import score_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          SATURATE        = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic keyUp,
  input  logic keyDown,
  input  logic atZero,
  input  logic atMax,
  input  logic carryInPos,
  input  logic carryInNeg,
  input  logic clearFlags,
  output logic incrementOutPos,
  output logic incrementOutNeg,
  output logic busy,
  output logic overflow,
  output logic underflow
);

  logic   up_level, up_rise, dn_level, dn_rise;
  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  logic   pos_d, neg_d, busy_d;

  key_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_up (
    .Clock (Clock),
    .Reset (Reset),
    .key   (keyUp),
    .level (up_level),
    .rise  (up_rise)
  );

  key_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_down (
    .Clock (Clock),
    .Reset (Reset),
    .key   (keyDown),
    .level (dn_level),
    .rise  (dn_rise)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q         <= IDLE;
      dir_q           <= UP;
      incrementOutPos <= 1'b0;
      incrementOutNeg <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      incrementOutPos <= pos_d;
      incrementOutNeg <= neg_d;
      busy            <= busy_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (up_rise && dn_rise) begin
          state_d = WAIT_RELEASE;
        end else if (up_rise) begin
          if (SATURATE && atMax) begin
            state_d = WAIT_RELEASE;
          end else begin
            state_d = PULSE;
            dir_d   = UP;
          end
        end else if (dn_rise) begin
          if (SATURATE && atZero) begin
            state_d = WAIT_RELEASE;
          end else begin
            state_d = PULSE;
            dir_d   = DOWN;
          end
        end
      end
      PULSE:        state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!up_level && !dn_level) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    pos_d  = (state_d == PULSE) && (dir_d == UP);
    neg_d  = (state_d == PULSE) && (dir_d == DOWN);
    busy_d = (state_d != IDLE);
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (carryInPos)      overflow <= 1'b1;
      else if (clearFlags) overflow <= 1'b0;
      if (carryInNeg)      underflow <= 1'b1;
      else if (clearFlags) underflow <= 1'b0;
    end
  end

endmodule

// File: doc/score_input_ctrl.md
# score_input_ctrl

Front end of the score-counter chain. It turns two raw, asynchronous player keys into clean single-cycle increment/decrement requests, which drive the least-significant digit's positive/negative increment inputs. It also watches the most-significant digit's carry/borrow outputs and the chain's zero/max indications. From these it enforces saturation at 0 and at full scale, and keeps sticky overflow/underflow flags.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages in each key synchronizer (minimum 2).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a key level is accepted (minimum 1).
- SATURATE, 1: 1 = suppress requests that would wrap (up at max, down at zero); 0 = pass them through.

Ports:
- Clock  in  1  single clock for the whole block.
- Reset  in  1  asynchronous, active-low reset.
- keyUp  in  1  raw "score up" key, active-high, asynchronous to Clock.
- keyDown  in  1  raw "score down" key, active-high, asynchronous to Clock.
- atZero  in  1  whole chain displays 0.
- atMax  in  1  whole chain displays its maximum (all nines).
- carryInPos  in  1  most-significant digit's wrap-up pulse.
- carryInNeg  in  1  most-significant digit's wrap-down pulse.
- clearFlags  in  1  synchronous clear of overflow and underflow.
- incrementOutPos  out  1  single-cycle increment request to the least-significant digit.
- incrementOutNeg  out  1  single-cycle decrement request to the least-significant digit.
- busy  out  1  high while a key press is being serviced (PULSE or WAIT_RELEASE).
- overflow  out  1  sticky; a wrap-up was observed.
- underflow  out  1  sticky; a wrap-down was observed.

## Operation
Key conditioning, per key:
- Synchronize through SYNC_STAGES flip-flops.
- A counter tracks the cycles in which the synchronized value differs from the current debounced level.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Any cycle in which the two values agree also clears the counter.
- A rise flag is high for one cycle when the debounced level goes from 0 to 1.

Control FSM, states IDLE, PULSE, WAIT_RELEASE:
- IDLE, upRise only: if SATURATE and atMax, go to WAIT_RELEASE with no request. Otherwise, go to PULSE with dir=up.
- IDLE, downRise only: if SATURATE and atZero, go to WAIT_RELEASE with no request. Otherwise, go to PULSE with dir=down.
- IDLE, upRise and downRise in the same cycle: ambiguous. Go to WAIT_RELEASE and issue no request.
- PULSE: drive exactly one of incrementOutPos/incrementOutNeg for one cycle, per dir, then go to WAIT_RELEASE.
- WAIT_RELEASE: return to IDLE only when both debounced levels are 0. No rise is accepted in this state, so holding a key never auto-repeats.
- Outputs are registered (Moore) and decode from state and dir only. incrementOutPos and incrementOutNeg are never high together.

Flags:
- overflow sets on carryInPos; underflow sets on carryInNeg.
- clearFlags clears both. If a set and a clear occur in the same cycle, the set wins.
- With SATURATE=1 the flags can set only if the chain is driven by another source.

## Timing
- Reset asserted: all flops clear at once. State=IDLE, synchronizers=0, debounced levels=0, counters=0.
- Outputs during and after reset: incrementOutPos=0, incrementOutNeg=0, busy=0, overflow=0, underflow=0.
- A key held through reset release is treated as a fresh press: its debounced level starts at 0, so it produces a rise.
- Latency: take the first edge that samples keyUp=1 as edge 1. Then:
  - the debounced level rises after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults);
  - incrementOutPos is high from edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (7) to edge +2 (8), exactly one cycle.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no request.
- Release takes the same SYNC_STAGES+DEBOUNCE_CYCLES cycles for the debounced level to fall. IDLE is re-entered one edge later.
- Minimum spacing between requests: 2·(SYNC_STAGES+DEBOUNCE_CYCLES)+2 cycles.
- atZero/atMax are sampled in the IDLE cycle in which the rise is seen.
- Flags update on the edge after carryInPos/carryInNeg or clearFlags.

## Structure
- Shared package score_pkg holds the FSM state enum (IDLE, PULSE, WAIT_RELEASE), a dir enum (UP, DOWN), and the default SYNC_STAGES and DEBOUNCE_CYCLES constants.
- Sub-module key_conditioner contains the synchronizer, debounce counter and rise detector. It is instantiated twice, for keyUp and keyDown.
- The top level holds the FSM, the saturation check and the flag registers.

## Test plan
- Reset: hold Reset=0 with keyUp=1 → all outputs 0. Release Reset → exactly one incrementOutPos pulse, high from edge 7 to edge 8.
- Glitch: keyUp high for 3 cycles (defaults) → no pulse, busy stays 0.
- Hold and re-press: keyDown held for 50 cycles → one incrementOutNeg pulse only. Release, then press again after the debounce interval → a second pulse.
- Simultaneous press: keyUp and keyDown rise on the same edge → no pulse, busy=1 until both are released.
- Saturation: atMax=1 with SATURATE=1, press keyUp → no pulse. Repeat with SATURATE=0 → pulse.
- Flags: carryInPos for one cycle → overflow=1 and sticky. Assert clearFlags together with carryInNeg → overflow=0, underflow=1.
